// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV64M divide path.
// Holds the {opcode, funct3} constants of the eight divide/remainder ops,
// the issue-controller state type, and small op-classification helpers
// used by the issue controller and the operand extender.
package muldiv_pkg;

    localparam int DIV_OP_W = 10;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OP32 = 7'b0111011;

    localparam logic [DIV_OP_W-1:0] DIV   = {OPC_OP,   3'b100};
    localparam logic [DIV_OP_W-1:0] DIVU  = {OPC_OP,   3'b101};
    localparam logic [DIV_OP_W-1:0] REM   = {OPC_OP,   3'b110};
    localparam logic [DIV_OP_W-1:0] REMU  = {OPC_OP,   3'b111};
    localparam logic [DIV_OP_W-1:0] DIVW  = {OPC_OP32, 3'b100};
    localparam logic [DIV_OP_W-1:0] DIVUW = {OPC_OP32, 3'b101};
    localparam logic [DIV_OP_W-1:0] REMW  = {OPC_OP32, 3'b110};
    localparam logic [DIV_OP_W-1:0] REMUW = {OPC_OP32, 3'b111};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } div_state_t;

    function automatic logic is_div_op(input logic [DIV_OP_W-1:0] op);
        return (op == DIV)  || (op == DIVU)  || (op == REM)  || (op == REMU) ||
               (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_w_op(input logic [DIV_OP_W-1:0] op);
        return (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_signed_op(input logic [DIV_OP_W-1:0] op);
        return (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
    endfunction

endpackage

// File: rtl/div_operand_ext.sv
// Operand preparation for the divider (purely combinational).
// 64-bit ops pass both operands through; signed W ops sign-extend bits
// [31:0], unsigned W ops zero-extend bits [31:0].
// Ports:
//   op       : {opcode, funct3} of the op being prepared
//   rs1, rs2 : raw source operands
//   dividend : prepared dividend
//   diviser  : prepared divisor
module div_operand_ext
    import muldiv_pkg::*;
(
    input  logic [DIV_OP_W-1:0] op,
    input  logic [63:0]         rs1,
    input  logic [63:0]         rs2,
    output logic [63:0]         dividend,
    output logic [63:0]         diviser
);

    logic        w_op;
    logic        s_op;
    logic [63:0] src [2];
    logic [63:0] ext [2];

    assign w_op   = is_w_op(op);
    assign s_op   = is_signed_op(op);
    assign src[0] = rs1;
    assign src[1] = rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ext
            assign ext[gi] = !w_op ? src[gi] :
                             s_op  ? {{32{src[gi][31]}}, src[gi][31:0]} :
                                     {32'd0, src[gi][31:0]};
        end
    endgenerate

    assign dividend = ext[0];
    assign diviser  = ext[1];

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle 64-bit divider.
// Decodes the RV64M divide/remainder ops, latches and extends operands,
// strobes the divider start, stalls the pipeline while the divide runs,
// presents the captured result for write-back, and drains a divide that
// was flushed after the divider accepted it (the divider cannot abort).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ex_valid_i        : EX holds a valid instruction
//   inst_op_f3_i      : {opcode, funct3} of the EX instruction
//   rs1_data_i/rs2_   : dividend / divisor sources
//   rd_addr_i         : destination register
//   flush_i           : kill EX instruction and any in-flight divide
//   stall_o           : freeze IF/ID/EX
//   wb_valid_o        : one-cycle result-valid
//   wb_rd_addr_o      : destination of the result
//   wb_data_o         : quotient or remainder
//   div_dividend_o    : divider dividend
//   div_diviser_o     : divider divisor
//   div_op_o          : divider op code
//   div_ready_o       : divider start strobe
//   div_rem_data_i    : divider result
//   div_finish_i      : divider done pulse
//   div_busy_i        : divider busy
module div_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int OP_W = DIV_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    input  logic [OP_W-1:0] inst_op_f3_i,
    input  logic [63:0]     rs1_data_i,
    input  logic [63:0]     rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [63:0]     wb_data_o,
    output logic [63:0]     div_dividend_o,
    output logic [63:0]     div_diviser_o,
    output logic [OP_W-1:0] div_op_o,
    output logic            div_ready_o,
    input  logic [63:0]     div_rem_data_i,
    input  logic            div_finish_i,
    input  logic            div_busy_i
);

    div_state_t      state_reg, state_next;
    logic [63:0]     rs1_reg, rs2_reg;
    logic [OP_W-1:0] op_reg;
    logic [4:0]      rd_reg;
    logic [63:0]     wb_data_reg;
    logic [4:0]      wb_rd_reg;

    logic is_div;
    logic issue_req;
    logic latch_en;
    logic capture_en;

    assign is_div    = is_div_op(inst_op_f3_i);
    assign issue_req = ex_valid_i & is_div & !flush_i;

    always_comb begin
        state_next  = state_reg;
        stall_o     = 1'b0;
        div_ready_o = 1'b0;
        wb_valid_o  = 1'b0;
        latch_en    = 1'b0;
        capture_en  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Stall even while waiting for a busy divider so the op is held.
                stall_o = issue_req;
                if (issue_req && !div_busy_i) begin
                    latch_en   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The divider accepts this cycle regardless of flush, so a
                // flush here must still wait out the divide.
                div_ready_o = 1'b1;
                stall_o     = !flush_i;
                state_next  = flush_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall_o = !flush_i;
                if (flush_i) begin
                    // Finish coinciding with flush means the divider is
                    // already idle: nothing left to drain.
                    state_next = div_finish_i ? S_IDLE : S_DRAIN;
                end else if (div_finish_i) begin
                    capture_en = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                wb_valid_o = 1'b1;
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                // A new divide waiting in EX must be held until the drain ends.
                stall_o = ex_valid_i & is_div;
                if (div_finish_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            op_reg      <= '0;
            rd_reg      <= '0;
            wb_data_reg <= '0;
            wb_rd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                rs1_reg <= rs1_data_i;
                rs2_reg <= rs2_data_i;
                op_reg  <= inst_op_f3_i;
                rd_reg  <= rd_addr_i;
            end
            if (capture_en) begin
                wb_data_reg <= div_rem_data_i;
                wb_rd_reg   <= rd_reg;
            end
        end
    end

    div_operand_ext u_ext (
        .op       (op_reg),
        .rs1      (rs1_reg),
        .rs2      (rs2_reg),
        .dividend (div_dividend_o),
        .diviser  (div_diviser_o)
    );

    assign div_op_o     = op_reg;
    assign wb_data_o    = wb_data_reg;
    assign wb_rd_addr_o = wb_rd_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

    localparam logic [9:0] T_DIV   = 10'b0110011100;
    localparam logic [9:0] T_DIVU  = 10'b0110011101;
    localparam logic [9:0] T_REM   = 10'b0110011110;
    localparam logic [9:0] T_REMU  = 10'b0110011111;
    localparam logic [9:0] T_DIVW  = 10'b0111011100;
    localparam logic [9:0] T_DIVUW = 10'b0111011101;
    localparam logic [9:0] T_REMW  = 10'b0111011110;
    localparam logic [9:0] T_REMUW = 10'b0111011111;
    localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

    logic        clk, rst;
    logic        ex_valid, flush;
    logic [9:0]  inst_op;
    logic [63:0] rs1, rs2;
    logic [4:0]  rd_addr;
    logic        stall_o, wb_valid_o, div_ready_o;
    logic [4:0]  wb_rd_addr_o;
    logic [63:0] wb_data_o, div_dividend_o, div_diviser_o;
    logic [9:0]  div_op_o;
    logic [63:0] div_rem_data;
    logic        div_finish, div_busy;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid),
        .inst_op_f3_i   (inst_op),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .rd_addr_i      (rd_addr),
        .flush_i        (flush),
        .stall_o        (stall_o),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_addr_o   (wb_rd_addr_o),
        .wb_data_o      (wb_data_o),
        .div_dividend_o (div_dividend_o),
        .div_diviser_o  (div_diviser_o),
        .div_op_o       (div_op_o),
        .div_ready_o    (div_ready_o),
        .div_rem_data_i (div_rem_data),
        .div_finish_i   (div_finish),
        .div_busy_i     (div_busy)
    );

    // Divider stand-in: accepts on the start strobe, finishes 67 cycles
    // later, and computes from the operands it sees at that moment.
    function automatic logic [63:0] stub_calc(input logic [9:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [63:0] q, r, res;
        logic sgn;
        sgn = !op[0];
        if (b == 64'd0) begin
            q = '1; r = a;
        end else if (sgn && a == MIN64 && b == '1) begin
            q = a; r = 64'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        res = op[1] ? r : q;
        if (op[6]) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    int stub_cnt;
    always @(posedge clk) begin
        if (rst) begin
            div_busy <= 1'b0;
            stub_cnt <= 0;
        end else if (!div_busy) begin
            if (div_ready_o) begin
                div_busy <= 1'b1;
                stub_cnt <= 0;
            end
        end else if (stub_cnt == 66) begin
            div_busy <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign div_finish = div_busy && (stub_cnt == 66);
    always_comb begin
        div_rem_data = 64'd0;
        if (div_finish) div_rem_data = stub_calc(div_op_o, div_dividend_o, div_diviser_o);
    end

    // Reference model: RISC-V semantics on the raw sources, 32-bit
    // arithmetic for W ops.
    function automatic logic [63:0] ref_calc(input logic [9:0] op, input logic [63:0] x,
                                             input logic [63:0] y);
        longint sa, sb;
        longint unsigned ua, ub;
        int sa32, sb32, r32;
        int unsigned ua32, ub32;
        sa = x; sb = y; ua = x; ub = y;
        sa32 = x[31:0]; sb32 = y[31:0]; ua32 = x[31:0]; ub32 = y[31:0];
        case (op)
            T_DIV: begin
                if (sb == 0) return '1;
                if (sa == longint'(MIN64) && sb == -1) return x;
                return sa / sb;
            end
            T_REM: begin
                if (sb == 0) return x;
                if (sa == longint'(MIN64) && sb == -1) return 64'd0;
                return sa % sb;
            end
            T_DIVU: return (ub == 0) ? '1 : ua / ub;
            T_REMU: return (ub == 0) ? x : ua % ub;
            T_DIVW: begin
                if (sb32 == 0) r32 = -1;
                else if (sa32 == 32'h8000_0000 && sb32 == -1) r32 = sa32;
                else r32 = sa32 / sb32;
                return longint'(r32);
            end
            T_REMW: begin
                if (sb32 == 0) r32 = sa32;
                else if (sa32 == 32'h8000_0000 && sb32 == -1) r32 = 0;
                else r32 = sa32 % sb32;
                return longint'(r32);
            end
            T_DIVUW: begin
                r32 = (ub32 == 0) ? -1 : int'(ua32 / ub32);
                return longint'(r32);
            end
            T_REMUW: begin
                r32 = (ub32 == 0) ? int'(ua32) : int'(ua32 % ub32);
                return longint'(r32);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_ext(input logic [9:0] op, input logic [63:0] x);
        int s32;
        int unsigned u32;
        s32 = x[31:0];
        u32 = x[31:0];
        case (op)
            T_DIVW, T_REMW:   return longint'(s32);
            T_DIVUW, T_REMUW: return 64'(u32);
            default:          return x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Full divide from request (cycle 0) to write-back; called at posedge+1.
    task automatic run_op(input string name, input logic [9:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] e_dvd,
                          input logic [63:0] e_dvs, input logic [63:0] e_data);
        int wb_cyc, ready_cnt;
        bit stall_bad;
        logic [63:0] got_data;
        logic [4:0]  got_rd;
        wb_cyc = -1; ready_cnt = 0; stall_bad = 0; got_data = '0; got_rd = '0;
        ex_valid = 1'b1; inst_op = op; rs1 = a; rs2 = b; rd_addr = rd;
        for (int c = 0; c < 200 && wb_cyc < 0; c++) begin
            @(negedge clk);
            if (div_ready_o) ready_cnt++;
            if (c == 1) begin
                chk({name, " dividend"}, div_dividend_o, e_dvd);
                chk({name, " diviser"}, div_diviser_o, e_dvs);
                chk({name, " div_op"}, 64'(div_op_o), 64'(op));
            end
            if (c == 60) chk({name, " dividend held"}, div_dividend_o, e_dvd);
            if (c <= 69 && stall_o !== (c < 69)) stall_bad = 1'b1;
            if (wb_valid_o) begin
                wb_cyc = c; got_data = wb_data_o; got_rd = wb_rd_addr_o;
            end
            @(posedge clk); #1;
            if (c == 1) begin
                rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
                rd_addr = 5'($urandom);
            end
        end
        ex_valid = 1'b0; inst_op = '0; rs1 = '0; rs2 = '0; rd_addr = '0;
        chk({name, " wb cycle"}, 64'(wb_cyc), 64'd69);
        chk({name, " wb data"}, got_data, e_data);
        chk({name, " wb rd"}, 64'(got_rd), 64'(rd));
        chk({name, " start pulses"}, 64'(ready_cnt), 64'd1);
        chk({name, " stall window ok"}, 64'(stall_bad), 64'd0);
        $display("op %s: rs1=%h rs2=%h -> wb=%h at cycle %0d", name, a, b, got_data, wb_cyc);
    endtask

    // DIVU 30/6 with a one-cycle flush in cycle fc.
    task automatic run_flush(input int fc);
        int wb_cnt, wb_cyc, ready_cnt;
        logic stall_at;
        logic [63:0] got;
        wb_cnt = 0; wb_cyc = -1; ready_cnt = 0; stall_at = 1'b1; got = '0;
        ex_valid = 1'b1; inst_op = T_DIVU; rs1 = 64'd30; rs2 = 64'd6; rd_addr = 5'd7;
        for (int c = 0; c < 76; c++) begin
            if (c == fc) flush = 1'b1;
            @(negedge clk);
            if (c == fc) stall_at = stall_o;
            if (div_ready_o) ready_cnt++;
            if (wb_valid_o) begin
                wb_cnt++; wb_cyc = c; got = wb_data_o;
            end
            @(posedge clk); #1;
            if (c == fc) begin
                flush = 1'b0; ex_valid = 1'b0;
            end
        end
        chk($sformatf("flush@%0d stall", fc), 64'(stall_at), 64'd0);
        chk($sformatf("flush@%0d start pulses", fc), 64'(ready_cnt), 64'd1);
        chk($sformatf("flush@%0d wb count", fc), 64'(wb_cnt), (fc == 69) ? 64'd1 : 64'd0);
        if (fc == 69) begin
            chk("flush in DONE wb cycle", 64'(wb_cyc), 64'd69);
            chk("flush in DONE wb data", got, 64'd5);
        end
        $display("flush at cycle %0d: wb_count=%0d", fc, wb_cnt);
    endtask

    // Flush in cycle 20, new DIVU 9/3 arriving in cycle 25 during the drain.
    task automatic run_flush_reissue();
        int wb_cyc;
        bit stall_bad, early_stall;
        logic stall20;
        logic [63:0] got;
        logic [4:0]  got_rd;
        wb_cyc = -1; stall_bad = 0; early_stall = 0; stall20 = 1'b1; got = '0; got_rd = '0;
        ex_valid = 1'b1; inst_op = T_DIVU; rs1 = 64'd50; rs2 = 64'd5; rd_addr = 5'd3;
        for (int c = 0; c < 300 && wb_cyc < 0; c++) begin
            if (c == 20) flush = 1'b1;
            if (c == 21) begin flush = 1'b0; ex_valid = 1'b0; end
            if (c == 25) begin
                ex_valid = 1'b1; inst_op = T_DIVU; rs1 = 64'd9; rs2 = 64'd3; rd_addr = 5'd4;
            end
            @(negedge clk);
            if (c == 20) stall20 = stall_o;
            if (c >= 21 && c <= 24 && stall_o) early_stall = 1'b1;
            if (wb_valid_o) begin
                wb_cyc = c; got = wb_data_o; got_rd = wb_rd_addr_o;
            end else if (c >= 25 && !stall_o) begin
                stall_bad = 1'b1;
            end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0; inst_op = '0; rs1 = '0; rs2 = '0; rd_addr = '0;
        chk("flush mid stall@20", 64'(stall20), 64'd0);
        chk("flush mid no stall 21..24", 64'(early_stall), 64'd0);
        chk("reissue held stall", 64'(stall_bad), 64'd0);
        chk("reissue wb cycle", 64'(wb_cyc), 64'd138);
        chk("reissue wb data", got, 64'd3);
        chk("reissue wb rd", 64'(got_rd), 64'd4);
        $display("flush+reissue: wb=%h at cycle %0d", got, wb_cyc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " stall"}, 64'(stall_o), 64'd0);
        chk({tag, " wb_valid"}, 64'(wb_valid_o), 64'd0);
        chk({tag, " wb_rd"}, 64'(wb_rd_addr_o), 64'd0);
        chk({tag, " wb_data"}, wb_data_o, 64'd0);
        chk({tag, " dividend"}, div_dividend_o, 64'd0);
        chk({tag, " diviser"}, div_diviser_o, 64'd0);
        chk({tag, " div_op"}, 64'(div_op_o), 64'd0);
        chk({tag, " div_ready"}, 64'(div_ready_o), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [9:0]  op;
        logic [63:0] a, b;
        logic [4:0]  rd;
        logic [63:0] dvd, dvs, data;
    } vec_t;

    vec_t vecs[11];
    logic [9:0] ops[8];

    initial begin
        vecs[0]  = '{"DIVU 100/7", T_DIVU, 64'd100, 64'd7, 5'd1, 64'd100, 64'd7, 64'd14};
        vecs[1]  = '{"REM -7%2", T_REM, -64'sd7, 64'd2, 5'd2, -64'sd7, 64'd2, '1};
        vecs[2]  = '{"DIV -7/2", T_DIV, -64'sd7, 64'd2, 5'd3, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{"DIVW ovf", T_DIVW, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd4,
                     64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000};
        vecs[4]  = '{"REMU 7%0", T_REMU, 64'd7, 64'd0, 5'd5, 64'd7, 64'd0, 64'd7};
        vecs[5]  = '{"DIVU 7/0", T_DIVU, 64'd7, 64'd0, 5'd6, 64'd7, 64'd0, '1};
        vecs[6]  = '{"DIVUW", T_DIVUW, 64'hFFFF_FFFF_FFFF_FFF0, 64'hAAAA_AAAA_0000_0010, 5'd7,
                     64'h0000_0000_FFFF_FFF0, 64'h10, 64'h0000_0000_0FFF_FFFF};
        vecs[7]  = '{"REMW", T_REMW, 64'h0000_0001_FFFF_FFF9, 64'h5, 5'd8,
                     64'hFFFF_FFFF_FFFF_FFF9, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[8]  = '{"REMUW", T_REMUW, 64'h0000_0000_8000_0005, 64'hF000_0000_0000_0010, 5'd9,
                     64'h0000_0000_8000_0005, 64'h10, 64'h5};
        vecs[9]  = '{"DIV ovf", T_DIV, MIN64, '1, 5'd10, MIN64, '1, MIN64};
        vecs[10] = '{"DIVUW bit31", T_DIVUW, 64'h0000_0000_8000_0000, 64'd1, 5'd31,
                     64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000};
        ops = '{T_DIV, T_DIVU, T_REM, T_REMU, T_DIVW, T_DIVUW, T_REMW, T_REMUW};

        rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; inst_op = '0;
        rs1 = '0; rs2 = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].dvd, vecs[i].dvs, vecs[i].data);

        run_flush(1);
        run_flush(68);
        run_flush(69);
        run_flush_reissue();

        // Reset in cycle 30 of a running divide.
        ex_valid = 1'b1; inst_op = T_DIVU; rs1 = 64'd1000; rs2 = 64'd10; rd_addr = 5'd9;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; ex_valid = 1'b0; inst_op = '0; rs1 = '0; rs2 = '0; rd_addr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after mid reset");
        @(posedge clk); #1;
        run_op("DIVU 8/2 after reset", T_DIVU, 64'd8, 64'd2, 5'd12, 64'd8, 64'd2, 64'd4);

        for (int i = 0; i < 24; i++) begin
            logic [9:0]  op;
            logic [63:0] a, b;
            op = ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0:       a = 64'($urandom_range(0, 1000));
                1:       a = MIN64;
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0:       b = 64'd0;
                1:       b = '1;
                2:       b = 64'($urandom_range(1, 50));
                3:       b = {$urandom, $urandom} >> $urandom_range(0, 63);
                default: b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) a[31:0] = 32'h8000_0000;
            run_op($sformatf("rand%0d op=%b", i, op), op, a, b, 5'($urandom),
                   ref_ext(op, a), ref_ext(op, b), ref_calc(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue controller for the multi-cycle 64-bit divider, sitting in the EX stage between the pipeline and the divider. It decodes the eight RV64M divide/remainder ops and prepares the operands, including sign- or zero-extending the low 32 bits for W variants. It pulses the divider start strobe and holds the pipeline stalled until the divider finishes. It then presents the captured result for write-back, and drains in-flight operations on flush, because the divider cannot abort.

## Interface
- `OP_W`, 10: width of the `{opcode[6:0], funct3}` op code shared with the divider.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `ex_valid_i`  in  1: EX stage holds a valid instruction.
- `inst_op_f3_i`  in  OP_W: `{opcode, funct3}` of the EX instruction.
- `rs1_data_i`  in  64: dividend source.
- `rs2_data_i`  in  64: divisor source.
- `rd_addr_i`  in  5: destination register.
- `flush_i`  in  1: kill the EX instruction and any in-flight divide.
- `stall_o`  out  1: freeze IF/ID/EX.
- `wb_valid_o`  out  1: result valid, one cycle.
- `wb_rd_addr_o`  out  5: destination for the result.
- `wb_data_o`  out  64: quotient or remainder.
- `div_dividend_o`  out  64: to divider `dividend`.
- `div_diviser_o`  out  64: to divider `diviser`.
- `div_op_o`  out  OP_W: to divider `inst_op_f3`.
- `div_ready_o`  out  1: to divider `div_ready`, start strobe.
- `div_rem_data_i`  in  64: divider result.
- `div_finish_i`  in  1: divider done, one-cycle pulse.
- `div_busy_i`  in  1: divider `busy_o`.

## Operation
- **Decode:** `is_div` = `inst_op_f3_i` matches any of DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- **Operand latch:** operands, op and rd are latched on IDLE→ISSUE and held constant until the FSM next returns to IDLE. The divider samples them combinationally throughout, including its zero-divisor path.
- **Extension rules:**
  - 64-bit ops pass operands through unchanged.
  - DIVW and REMW sign-extend bits [31:0] of both operands.
  - DIVUW and REMUW zero-extend bits [31:0] of both operands.
- **FSM states:** IDLE, ISSUE, WAIT, DONE, DRAIN.
  - IDLE: if `ex_valid_i & is_div & !flush_i & !div_busy_i`, go to ISSUE.
  - ISSUE: `div_ready_o`=1 for exactly one cycle, then go to WAIT. If `flush_i`, go to DRAIN, because the divider has already accepted.
  - WAIT: on `div_finish_i`, capture `div_rem_data_i` into `wb_data_o` and go to DONE. If `flush_i` is seen first, go to DRAIN.
  - DONE: `wb_valid_o`=1, then go to IDLE. No new issue is made from DONE.
  - DRAIN: no write-back. On `div_finish_i`, go to IDLE.
- **Stall:**
  - `stall_o` = 1 in IDLE when `ex_valid_i & is_div & !flush_i`.
  - `stall_o` = 1 in ISSUE and WAIT unless `flush_i`.
  - `stall_o` = 1 in DRAIN when `ex_valid_i & is_div`.
  - `stall_o` = 0 in DONE.
- **Simultaneous events:**
  - `flush_i` together with `div_finish_i` in WAIT: flush wins, so there is no `wb_valid_o` and the FSM goes to IDLE.
  - `flush_i` in DONE has no effect; the result is already committed.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE, and the latched regs are 0. The divider shares `rst`, so reset mid-operation returns both blocks to idle and no write-back is produced.
- **Latency:** with the request in cycle 0, the block is in ISSUE in cycle 1 and the divider accepts at the end of cycle 1. `div_finish_i` is high in cycle 68, and DONE with `wb_valid_o`=1 is in cycle 69.
- **Stall window:** `stall_o` is high in cycles 0..68 and low in 69.
- **Back-to-back ops:** the next div op can be issued 2 cycles after DONE (IDLE, then ISSUE). This guarantees the divider counter is back at 0.
- **Output stability:** `wb_data_o` and `wb_rd_addr_o` hold their value until the next capture.

## Structure
- A shared `muldiv_pkg` holds:
  - the eight opcode constants (e.g. DIV = 10'b0110011100, REMUW = 10'b0111011111);
  - the FSM state enum;
  - an `is_w_op` function for the W variants;
  - an `is_signed_op` function for the signed variants.
- The operand-extension logic is a natural sub-module, `div_operand_ext` (combinational, 64-bit in and out).
- The divider is instantiated by the parent, not inside this block.

## Test plan
- **DIVU:** 100 / 7 → `wb_data_o`=14, `wb_valid_o` in cycle 69, `stall_o` high in cycles 0..68.
- **REM:** -7 % 2 → 0xFFFF_FFFF_FFFF_FFFF. **DIV:** -7 / 2 → 0xFFFF_FFFF_FFFF_FFFD.
- **DIVW:** rs1 = 0x1234_5678_8000_0000, rs2 = 0xFFFF_FFFF → `div_dividend_o` = 0xFFFF_FFFF_8000_0000, `div_diviser_o` = all ones, `wb_data_o` = 0xFFFF_FFFF_8000_0000.
- **REMU by zero:** 7 % 0 → `wb_data_o` = 7. **DIVU by zero:** 7 / 0 → all ones.
- **Flush mid-divide:** `flush_i` in cycle 20 → `stall_o` drops, no `wb_valid_o`. A new DIVU 9/3 in cycle 25 stalls until the drain finishes, is then issued, and produces 3.
- **Reset mid-divide:** `rst` in cycle 30 → all outputs 0 next cycle. A fresh DIVU 8/2 afterwards returns 4 with the normal 69-cycle latency.
